// File: rtl/core_seq_ctrl.sv
// Instruction sequencer: instruction pointer, flag branches, call/return stack
// and a segment counter chain fed by the carry out of the instruction pointer.
module core_seq_ctrl #(
  parameter int unsigned IP_W        = 8,
  parameter int unsigned SEG_W       = 8,
  parameter int unsigned SEG_N       = 3,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [IP_W+7:0]              COMMAND_INPUT,
  input  logic                         cmd_valid,
  input  logic                         store_busy,
  input  logic                         fl_zf,
  input  logic                         fl_cf,
  output logic [IP_W-1:0]              IP,
  output logic [SEG_N*SEG_W-1:0]       SEG,
  output logic [SEG_W-1:0]             SEGMENT,
  output logic                         seg_valid,
  output logic [$clog2(STACK_DEPTH):0] stack_level,
  output logic                         stack_ovf,
  output logic                         stack_unf,
  output logic                         halted
);

  localparam int unsigned AW = $clog2(STACK_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_JMP    = 4'd1,
    OP_CALL   = 4'd2,
    OP_RET    = 4'd3,
    OP_BREQ   = 4'd4,
    OP_BRNE   = 4'd5,
    OP_BRCS   = 4'd6,
    OP_BRCC   = 4'd7,
    OP_SEGLD  = 4'd8,
    OP_SEGGET = 4'd9,
    OP_HALT   = 4'd10
  } opc_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IP_W-1:0]   ip_q, ip_d;
  logic [SEG_W-1:0]  seg_q [SEG_N];
  logic [SEG_W-1:0]  seg_d [SEG_N];
  logic [SEG_W-1:0]  segment_q, segment_d;
  logic              seg_valid_q, seg_valid_d;
  logic [LW-1:0]     level_q, level_d;
  logic [IP_W-1:0]   stack_q [STACK_DEPTH];
  logic [IP_W-1:0]   stack_d [STACK_DEPTH];
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [3:0]        opc;
  logic [3:0]        sel;
  logic [IP_W-1:0]   dat;
  logic [IP_W-1:0]   ip_inc;
  logic [AW-1:0]     top_idx;
  logic              exec;
  logic              sel_ok;
  logic              stack_full;
  logic              stack_empty;
  logic              seq_inc;
  logic              seg_ld;
  logic              carry;
  logic              wrap;

  assign opc         = COMMAND_INPUT[IP_W+7:IP_W+4];
  assign sel         = COMMAND_INPUT[IP_W+3:IP_W];
  assign dat         = COMMAND_INPUT[IP_W-1:0];
  assign ip_inc      = ip_q + 1'b1;
  assign top_idx     = level_q[AW-1:0] - 1'b1;
  assign exec        = cmd_valid & ~store_busy & (state_q == ST_RUN);
  assign sel_ok      = (32'(sel) < SEG_N);
  assign stack_full  = (level_q == LW'(STACK_DEPTH));
  assign stack_empty = (level_q == '0);

  always_comb begin
    state_d     = state_q;
    ip_d        = ip_q;
    seg_d       = seg_q;
    segment_d   = segment_q;
    seg_valid_d = 1'b0;
    level_d     = level_q;
    stack_d     = stack_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    seq_inc     = 1'b0;
    seg_ld      = 1'b0;
    carry       = 1'b0;
    wrap        = 1'b0;

    if (exec) begin
      case (opc)
        OP_JMP: ip_d = dat;
        OP_CALL: begin
          if (stack_full) begin
            ovf_d   = 1'b1;
            seq_inc = 1'b1;
          end else begin
            stack_d[level_q[AW-1:0]] = ip_inc;
            level_d = level_q + 1'b1;
            ip_d    = dat;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            unf_d   = 1'b1;
            seq_inc = 1'b1;
          end else begin
            ip_d    = stack_q[top_idx];
            level_d = level_q - 1'b1;
          end
        end
        OP_BREQ: if (fl_zf)  ip_d = dat; else seq_inc = 1'b1;
        OP_BRNE: if (!fl_zf) ip_d = dat; else seq_inc = 1'b1;
        OP_BRCS: if (fl_cf)  ip_d = dat; else seq_inc = 1'b1;
        OP_BRCC: if (!fl_cf) ip_d = dat; else seq_inc = 1'b1;
        OP_SEGLD: begin
          seq_inc = 1'b1;
          seg_ld  = sel_ok;
        end
        OP_SEGGET: begin
          seq_inc = 1'b1;
          if (sel_ok) begin
            seg_valid_d = 1'b1;
            for (int unsigned k = 0; k < SEG_N; k++) begin
              if (32'(sel) == k) segment_d = seg_q[k];
            end
          end
        end
        OP_HALT: state_d = ST_HALT;
        default: seq_inc = 1'b1;
      endcase
    end

    if (seq_inc) ip_d = ip_inc;

    // A load wins for its own segment, but the carry it passes on is judged
    // from that segment's old value.
    carry = seq_inc && (ip_q == '1);
    for (int unsigned k = 0; k < SEG_N; k++) begin
      wrap = carry && (seg_q[k] == '1);
      if (seg_ld && (32'(sel) == k)) seg_d[k] = dat[SEG_W-1:0];
      else if (carry)                seg_d[k] = seg_q[k] + 1'b1;
      carry = wrap;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_RUN;
      ip_q        <= '0;
      seg_q       <= '{default: '0};
      segment_q   <= '0;
      seg_valid_q <= 1'b0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ip_q        <= ip_d;
      seg_q       <= seg_d;
      segment_q   <= segment_d;
      seg_valid_q <= seg_valid_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
    stack_q <= stack_d;
  end

  always_comb begin
    SEG = '0;
    for (int unsigned k = 0; k < SEG_N; k++) begin
      SEG[k*SEG_W +: SEG_W] = seg_q[k];
    end
  end

  assign IP          = ip_q;
  assign SEGMENT     = segment_q;
  assign seg_valid   = seg_valid_q;
  assign stack_level = level_q;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;
  assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: directed vector table, stack/carry sequences and
// random stimulus checked against a queue/integer reference model.
module tb_core_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] COMMAND_INPUT = '0;
  logic        cmd_valid = 1'b0;
  logic        store_busy = 1'b0;
  logic        fl_zf = 1'b0;
  logic        fl_cf = 1'b0;
  logic [7:0]  IP;
  logic [23:0] SEG;
  logic [7:0]  SEGMENT;
  logic        seg_valid;
  logic [3:0]  stack_level;
  logic        stack_ovf;
  logic        stack_unf;
  logic        halted;

  core_seq_ctrl #(
    .IP_W(8),
    .SEG_W(8),
    .SEG_N(3),
    .STACK_DEPTH(8)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .COMMAND_INPUT(COMMAND_INPUT),
    .cmd_valid(cmd_valid),
    .store_busy(store_busy),
    .fl_zf(fl_zf),
    .fl_cf(fl_cf),
    .IP(IP),
    .SEG(SEG),
    .SEGMENT(SEGMENT),
    .seg_valid(seg_valid),
    .stack_level(stack_level),
    .stack_ovf(stack_ovf),
    .stack_unf(stack_unf),
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: the segment chain is one 24-bit integer counter.
  int              m_ip = 0;
  longint unsigned m_chain = 0;
  int              stk[$];
  bit              m_ovf = 0, m_unf = 0, m_halt = 0, m_sv = 0;
  int              m_segm = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit vld, input bit busy,
                            input int opc, input int sel, input int dat,
                            input bit zf, input bit cf);
    bit seq;
    bit ld;
    if (rst) begin
      m_ip = 0; m_chain = 0; stk.delete();
      m_ovf = 0; m_unf = 0; m_halt = 0; m_sv = 0; m_segm = 0;
      return;
    end
    m_sv = 0;
    if (!vld || busy || m_halt) return;
    seq = 0;
    ld  = 0;
    case (opc)
      1: m_ip = dat;
      2: if (stk.size() == 8) begin m_ovf = 1; seq = 1; end
         else begin stk.push_back((m_ip + 1) % 256); m_ip = dat; end
      3: if (stk.size() == 0) begin m_unf = 1; seq = 1; end
         else m_ip = stk.pop_back();
      4: if (zf)  m_ip = dat; else seq = 1;
      5: if (!zf) m_ip = dat; else seq = 1;
      6: if (cf)  m_ip = dat; else seq = 1;
      7: if (!cf) m_ip = dat; else seq = 1;
      8: begin seq = 1; ld = (sel < 3); end
      9: begin
        seq = 1;
        if (sel < 3) begin
          m_segm = int'((m_chain >> (8 * sel)) & 64'hFF);
          m_sv = 1;
        end
      end
      10: m_halt = 1;
      default: seq = 1;
    endcase
    if (seq) begin
      if (m_ip == 255) begin
        m_ip = 0;
        m_chain = (m_chain + 1) % (64'd1 << 24);
      end else begin
        m_ip = m_ip + 1;
      end
    end
    if (ld)
      m_chain = (m_chain & ~(64'hFF << (8 * sel))) | (longint'(dat) << (8 * sel));
  endtask

  task automatic cycle(input bit rst, input bit vld, input bit busy,
                       input bit [3:0] opc, input bit [3:0] sel, input bit [7:0] dat,
                       input bit zf, input bit cf);
    RESET = rst;
    cmd_valid = vld;
    store_busy = busy;
    COMMAND_INPUT = {opc, sel, dat};
    fl_zf = zf;
    fl_cf = cf;
    @(posedge CLK);
    model_step(rst, vld, busy, int'(opc), int'(sel), int'(dat), zf, cf);
    #1;
    chk("model_ip", IP, m_ip);
    chk("model_seg", SEG, m_chain);
    chk("model_segment", SEGMENT, m_segm);
    chk("model_seg_valid", seg_valid, m_sv);
    chk("model_level", stack_level, stk.size());
    chk("model_ovf", stack_ovf, m_ovf);
    chk("model_unf", stack_unf, m_unf);
    chk("model_halted", halted, m_halt);
  endtask

  typedef struct {
    bit        rst, vld, busy;
    bit [3:0]  opc, sel;
    bit [7:0]  dat;
    bit        zf, cf;
    bit [7:0]  e_ip;
    int        e_lvl;
    bit [23:0] e_seg;
    bit [7:0]  e_segm;
    bit        e_sv, e_halt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit vld, bit busy, bit [3:0] opc, bit [3:0] sel,
                              bit [7:0] dat, bit zf, bit cf, bit [7:0] e_ip, int e_lvl,
                              bit [23:0] e_seg, bit [7:0] e_segm, bit e_sv, bit e_halt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.busy = busy; v.opc = opc; v.sel = sel; v.dat = dat;
    v.zf = zf; v.cf = cf; v.e_ip = e_ip; v.e_lvl = e_lvl; v.e_seg = e_seg;
    v.e_segm = e_segm; v.e_sv = e_sv; v.e_halt = e_halt;
    return v;
  endfunction

  initial begin
    // rst vld busy opc sel dat zf cf | ip lvl seg segm sv halt
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 24'h0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 24'h0, 8'h00, 0, 0));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 0, 8'(i), 0, 24'h0, 8'h00, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 1, 0, 0, 8'h00, 0, 0, 8'h05, 0, 24'h0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4, 0, 8'h40, 1, 0, 8'h40, 0, 24'h0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 5, 0, 8'h10, 1, 0, 8'h41, 0, 24'h0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 7, 0, 8'h22, 0, 0, 8'h22, 0, 24'h0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 8'h03, 0, 0, 8'h03, 0, 24'h0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2, 0, 8'h80, 0, 0, 8'h80, 1, 24'h0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3, 0, 8'h00, 0, 0, 8'h04, 0, 24'h0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8, 0, 8'hFF, 0, 0, 8'h05, 0, 24'h0000FF, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 8'hFF, 0, 0, 8'hFF, 0, 24'h0000FF, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 24'h000100, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 8'hFF, 0, 0, 8'hFF, 0, 24'h000100, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 24'h000100, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8, 0, 8'hFF, 0, 0, 8'h01, 0, 24'h0001FF, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 8'hFF, 0, 0, 8'hFF, 0, 24'h0001FF, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8, 0, 8'h12, 0, 0, 8'h00, 0, 24'h000212, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8, 5, 8'h33, 0, 0, 8'h01, 0, 24'h000212, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8, 1, 8'h07, 0, 0, 8'h02, 0, 24'h000712, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 9, 1, 8'h00, 0, 0, 8'h03, 0, 24'h000712, 8'h07, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 0, 8'h04, 0, 24'h000712, 8'h07, 0, 0));
    tbl.push_back(mk(0, 1, 0, 10, 0, 8'h00, 0, 0, 8'h04, 0, 24'h000712, 8'h07, 0, 1));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 0, 8'h04, 0, 24'h000712, 8'h07, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 24'h0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 24'h0, 8'h00, 0, 0));

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].vld, tbl[i].busy, tbl[i].opc, tbl[i].sel, tbl[i].dat,
            tbl[i].zf, tbl[i].cf);
      chk($sformatf("vec%0d_ip", i), IP, tbl[i].e_ip);
      chk($sformatf("vec%0d_level", i), stack_level, tbl[i].e_lvl);
      chk($sformatf("vec%0d_seg", i), SEG, tbl[i].e_seg);
      chk($sformatf("vec%0d_segment", i), SEGMENT, tbl[i].e_segm);
      chk($sformatf("vec%0d_seg_valid", i), seg_valid, tbl[i].e_sv);
      chk($sformatf("vec%0d_halted", i), halted, tbl[i].e_halt);
    end

    // Nested calls to overflow, then returns to underflow.
    cycle(1, 0, 0, 0, 0, 8'h00, 0, 0);
    cycle(0, 1, 0, 2, 0, 8'h20, 0, 0);
    for (int i = 1; i < 8; i++) cycle(0, 1, 0, 2, 0, 8'(8'h20 + i), 0, 0);
    chk("nest_level8", stack_level, 8);
    chk("nest_ip", IP, 8'h27);
    chk("nest_no_ovf", stack_ovf, 0);
    cycle(0, 1, 0, 2, 0, 8'h99, 0, 0);
    chk("ovf_flag", stack_ovf, 1);
    chk("ovf_ip", IP, 8'h28);
    chk("ovf_level", stack_level, 8);
    cycle(0, 1, 0, 3, 0, 8'h00, 0, 0);
    chk("ret1_ip", IP, 8'h27);
    for (int i = 1; i < 8; i++) cycle(0, 1, 0, 3, 0, 8'h00, 0, 0);
    chk("ret8_ip", IP, 8'h01);
    chk("ret8_level", stack_level, 0);
    chk("ret8_no_unf", stack_unf, 0);
    cycle(0, 1, 0, 3, 0, 8'h00, 0, 0);
    chk("unf_flag", stack_unf, 1);
    chk("unf_ip", IP, 8'h02);
    chk("ovf_sticky", stack_ovf, 1);

    // Carry ripples through two all-ones segments into the top one.
    cycle(0, 1, 0, 8, 0, 8'hFF, 0, 0);
    cycle(0, 1, 0, 8, 1, 8'hFF, 0, 0);
    cycle(0, 1, 0, 8, 2, 8'hFF, 0, 0);
    cycle(0, 1, 0, 1, 0, 8'hFF, 0, 0);
    cycle(0, 1, 0, 6, 0, 8'h55, 0, 0);
    chk("wrap_all_seg", SEG, 24'h000000);
    chk("wrap_all_ip", IP, 8'h00);
    // Load in the middle of a carry: carry still passes on the old all-ones value.
    cycle(0, 1, 0, 8, 0, 8'hFF, 0, 0);
    cycle(0, 1, 0, 8, 1, 8'hFF, 0, 0);
    cycle(0, 1, 0, 1, 0, 8'hFF, 0, 0);
    cycle(0, 1, 0, 8, 1, 8'h3C, 0, 0);
    chk("ld_mid_carry_seg", SEG, 24'h013C00);

    // Random phase against the reference model.
    cycle(1, 0, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit       rst, vld, busy;
      bit [3:0] opc, sel;
      bit [7:0] dat;
      rst  = ($urandom_range(0, 199) == 0) || (m_halt && $urandom_range(0, 9) == 0);
      vld  = ($urandom_range(0, 99) < 85);
      busy = ($urandom_range(0, 99) < 20);
      opc  = 4'($urandom_range(0, 15));
      if (opc == 4'd10 && $urandom_range(0, 3) != 0) opc = 4'd0;
      sel  = 4'($urandom_range(0, 4));
      dat  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      cycle(rst, vld, busy, opc, sel, dat, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
Parametrised instruction sequencer for the MicroCPU core. It owns the instruction pointer, branches on ALU flags, and keeps an internal call/return stack of configurable depth. It also maintains an N-stage segment counter chain that carries out of the IP. It sits between the program store (which supplies COMMAND_INPUT) and the datapath decoders; the store can stall it through a busy input.

Parameters:
IP_W, 8, instruction pointer width and width of the command data field
SEG_W, 8, width of each segment register (SEG_W <= IP_W)
SEG_N, 3, number of chained segment registers (1..15)
STACK_DEPTH, 8, return-stack entries (power of two, >= 2)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
COMMAND_INPUT  in  8+IP_W  instruction word: [IP_W+7:IP_W+4]=OPC, [IP_W+3:IP_W]=SEL, [IP_W-1:0]=DAT
cmd_valid  in  1  COMMAND_INPUT holds a valid instruction this cycle
store_busy  in  1  program store busy; sequencer stalls
fl_zf  in  1  zero flag
fl_cf  in  1  carry flag
IP  out  IP_W  current instruction pointer
SEG  out  SEG_N*SEG_W  flattened segment registers; segment k at [k*SEG_W +: SEG_W]
SEGMENT  out  SEG_W  segment value selected by SEGGET
seg_valid  out  1  SEGMENT valid (one-cycle pulse)
stack_level  out  clog2(STACK_DEPTH)+1  stack occupancy
stack_ovf  out  1  sticky: CALL attempted while stack full
stack_unf  out  1  sticky: RET attempted while stack empty
halted  out  1  sequencer halted

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high. On RESET: IP=0, all SEG=0, SEGMENT=0, seg_valid=0, stack_level=0, stack_ovf=0, stack_unf=0, halted=0. Stack contents are don't-care. RESET mid-CALL or mid-stall wins unconditionally.
- Execute condition: exec = cmd_valid & ~store_busy & ~halted. If exec=0, all state holds and seg_valid=0.
- When exec=1, the opcode is decoded and takes effect at the next edge. seg_valid also goes to 0 in every cycle without SEGGET.
- Opcodes, each a single-cycle effect:
  - 0 NOP: IP+1.
  - 1 JMP: IP=DAT.
  - 2 CALL: push IP+1 (mod 2^IP_W), then IP=DAT.
  - 3 RET: pop, then IP=top.
  - 4 BREQ: IP = fl_zf ? DAT : IP+1.
  - 5 BRNE: IP = ~fl_zf ? DAT : IP+1.
  - 6 BRCS: IP = fl_cf ? DAT : IP+1.
  - 7 BRCC: IP = ~fl_cf ? DAT : IP+1.
  - 8 SEGLD: SEG[SEL] = DAT[SEG_W-1:0], IP+1.
  - 9 SEGGET: SEGMENT=SEG[SEL], seg_valid=1 for one cycle, IP+1.
  - 10 HALT: halted=1, IP holds.
  - 11-15: treated as NOP.
- SEL >= SEG_N on SEGLD or SEGGET: treated as NOP; no load, seg_valid=0.
- Stack:
  - CALL when stack_level==STACK_DEPTH: no push, IP+1, stack_ovf=1.
  - RET when stack_level==0: no pop, IP+1, stack_unf=1.
  - Sticky flags clear only on RESET.
  - Stack is LIFO; stack_level updates at the same edge as IP.
- Segment carry chain:
  - Only a sequential increment (NOP, not-taken branch, SEGLD, SEGGET, failed CALL/RET) of IP from all-ones to 0 increments SEG[0].
  - SEG[k] increments when SEG[k-1] wraps in the same cycle. All wraps are modulo 2^SEG_W.
  - JMP, taken branch, CALL and RET never carry, even when the target is 0.
  - SEG[SEN_N-1] wrap is discarded.
  - SEGLD to SEG[j] in a carry cycle: the load wins for SEG[j]. Carry into SEG[j+1..] uses SEG[j]'s old value: it propagates only if the old value was all-ones and SEG[j] would have received a carry.
- HALT: halted=1, IP holds. Only RESET clears it. SEGMENT holds its last value.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset/sequential: RESET for 2 cycles, then 5 NOPs with cmd_valid=1 → IP=5, SEG all 0, flags 0. Assert store_busy for 3 cycles → IP stays 5.
- Branches: fl_zf=1 with BREQ DAT=0x40 → IP=0x40. BRNE DAT=0x10 → IP=0x41. fl_cf=0 with BRCC DAT=0x22 → IP=0x22.
- Call/return: CALL 0x80 at IP=0x03 → IP=0x80, stack_level=1. RET → IP=0x04, stack_level=0. Nested 8 CALLs then a 9th → stack_ovf=1, IP=prev+1, stack_level=8. 9 RETs → last sets stack_unf=1.
- Carry chain: SEGLD SEL=0 DAT=0xFF, then JMP 0xFF, then NOP → IP=0, SEG[0]=0, SEG[1]=1. JMP 0xFF, then JMP 0x00 → no carry.
- Simultaneous: SEG[0]=0xFF, IP=0xFF, SEGLD SEL=0 DAT=0x12 → SEG[0]=0x12, SEG[1] incremented by 1. SEGLD SEL=5 (SEG_N=3) → no change, IP+1.
- SEGGET/HALT: SEGGET SEL=1 with SEG[1]=0x07 → SEGMENT=0x07, seg_valid high exactly 1 cycle. HALT → IP frozen for 10 cycles under NOPs. RESET → halted=0, IP=0.
